// File: rtl/exp7_controle_exibicao.sv
// Playback sequencer for the memory game: walks the move memory from address 0
// up to the captured round index, lighting each entry for T_ON cycles and then blanking it for T_OFF cycles.
module exp7_controle_exibicao #(
    parameter int T_ON   = 500,
    parameter int T_OFF  = 250,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        CARREGA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    localparam int T_MAX   = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TIMER_W = $clog2(T_MAX) + 1;
    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(T_OFF - 1);

    estado_t             estado;
    logic [TIMER_W-1:0]  timer;
    logic [ADDR_W-1:0]   rodada_cap;

    assign db_estado = estado;

    // Every transition clears the timer; abortar overrides everything, including a pending start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            timer      <= '0;
            rodada_cap <= '0;
            endereco   <= '0;
            leds       <= '0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
        end else if (abortar) begin
            estado   <= OCIOSO;
            timer    <= '0;
            endereco <= '0;
            leds     <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        estado     <= CARREGA;
                        timer      <= '0;
                        endereco   <= '0;
                        rodada_cap <= rodada;
                        ocupado    <= 1'b1;
                    end
                end
                CARREGA: begin
                    leds   <= dado_mem;
                    timer  <= '0;
                    estado <= ACENDE;
                end
                ACENDE: begin
                    if (timer == ON_LAST) begin
                        estado <= APAGA;
                        timer  <= '0;
                        leds   <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                APAGA: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        // Comparing before incrementing keeps endereco from ever wrapping.
                        if (endereco == rodada_cap) begin
                            estado  <= FIM;
                            ocupado <= 1'b0;
                            pronto  <= 1'b1;
                        end else begin
                            estado <= PROXIMO;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                PROXIMO: begin
                    endereco <= endereco + ADDR_W'(1);
                    timer    <= '0;
                    estado   <= CARREGA;
                end
                FIM: begin
                    timer  <= '0;
                    estado <= OCIOSO;
                end
                default: begin
                    estado  <= OCIOSO;
                    timer   <= '0;
                    leds    <= '0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule
